// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: request, scoreboard and regfile write signals of the writeback arbiter.
interface wb_port_arbiter_if;
   logic        v0, v1, rdy0, rdy1;
   logic [4:0]  a0, a1;
   logic [31:0] d0, d1;
   logic        claim_v, claim_rdy;
   logic [4:0]  claim_a;
   logic [4:0]  RA, RB;
   logic        hazA, hazB;
   logic        RegWrite;
   logic [4:0]  RW;
   logic [31:0] BusW;
   logic [31:0] pend;
   modport master (
      output v0, v1, a0, a1, d0, d1, claim_v, claim_a, RA, RB,
      input  rdy0, rdy1, claim_rdy, hazA, hazB, RegWrite, RW, BusW, pend
   );
   modport slave (
      input  v0, v1, a0, a1, d0, d1, claim_v, claim_a, RA, RB,
      output rdy0, rdy1, claim_rdy, hazA, hazB, RegWrite, RW, BusW, pend
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the regfile write port between ALU and long-latency results with a pending-write scoreboard.
module wb_port_arbiter #(
   parameter int MAX_WAIT = 4
) (
   input logic clk,
   input logic r_st,
   wb_port_arbiter_if.slave bus
);
   logic [3:0]  waitCnt;
   logic        blk0, starve, acc0, acc1, claimSet;
   logic [31:0] setMask, clrMask;
   always_comb begin
      blk0 = bus.pend[bus.a0] & (bus.a0 != 5'd0);
      starve = waitCnt == 4'(MAX_WAIT);
      bus.rdy1 = starve | !(bus.v0 & !blk0);
      bus.rdy0 = !blk0 & !(bus.v1 & starve);
      acc0 = bus.v0 & bus.rdy0;
      acc1 = bus.v1 & bus.rdy1;
      bus.claim_rdy = !bus.pend[bus.claim_a] | (bus.claim_a == 5'd0);
      claimSet = bus.claim_v & bus.claim_rdy & (bus.claim_a != 5'd0);
      setMask = claimSet ? 32'd1 << bus.claim_a : 32'd0;
      clrMask = acc1 ? 32'd1 << bus.a1 : 32'd0;
      // in-flight write still counts as a hazard until the regfile has it
      bus.hazA = (bus.RA != 5'd0) & (bus.pend[bus.RA] | (bus.RegWrite & (bus.RW == bus.RA)));
      bus.hazB = (bus.RB != 5'd0) & (bus.pend[bus.RB] | (bus.RegWrite & (bus.RW == bus.RB)));
   end
   always_ff @(posedge clk) begin
      if (r_st) begin
         waitCnt <= 4'd0;
         bus.pend <= 32'd0;
         bus.RegWrite <= 1'b0;
         bus.RW <= 5'd0;
         bus.BusW <= 32'd0;
      end else begin
         waitCnt <= (!bus.v1 || acc1) ? 4'd0 : starve ? waitCnt : waitCnt + 4'd1;
         // a claim landing on the register being retired wins
         bus.pend <= (bus.pend & ~clrMask) | setMask;
         bus.RegWrite <= acc1 ? bus.a1 != 5'd0 : acc0 ? bus.a0 != 5'd0 : 1'b0;
         bus.RW <= acc1 ? bus.a1 : acc0 ? bus.a0 : bus.RW;
         bus.BusW <= acc1 ? bus.d1 : acc0 ? bus.d0 : bus.BusW;
      end
   end
endmodule
